// File: rtl/gabor_pkg.sv
// gabor_pkg: shared constants, types, coefficients and FSM states for the
// gabor_conv5x5 streaming convolution engine.
//   - Frame/stride/width constants
//   - coef_t  : signed Q2.15 coefficient
//   - psum_t  : 11-bit unsigned centro-symmetric pair sum
//   - C_45 / C_90 / C_135 / C_180 : 13 taps each. Entry j (0-based) weights
//     pair sum s_(j+1) = pixel_(j+1) + pixel_(25-j). Entry 12 weights the
//     centre pixel alone.
//   - state_t : window-processing FSM states
package gabor_pkg;

  localparam int IMG_W  = 512;
  localparam int PAD_W  = IMG_W + 4;
  localparam int ADDR_W = 19;
  localparam int PIX_W  = 10;
  localparam int COEF_W = 18;
  localparam int FRAC   = 15;
  localparam int ACC_W  = 34;
  localparam int PSUM_W = 11;
  localparam int NTAP   = 13;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic [PSUM_W-1:0]        psum_t;

  // Largest result whose bits [FRAC+7:FRAC] still read as a valid 8-bit pixel.
  localparam logic signed [ACC_W-1:0] CLAMP_MAX = ACC_W'((256 << FRAC) - 1);

  localparam coef_t C_45 [NTAP] = '{
    -18'sd1638, -18'sd983,  18'sd655,  18'sd2621, 18'sd3277, -18'sd2294,
     18'sd1311,  18'sd5243, 18'sd4915, 18'sd3932, 18'sd8192,  18'sd13107,
     18'sd16384
  };
  localparam coef_t C_90 [NTAP] = '{
     18'sd328,   18'sd1638,  18'sd2949,  18'sd1638, 18'sd328,  -18'sd655,
    -18'sd3277, -18'sd6554, -18'sd3277, -18'sd655,  18'sd2621,  18'sd11141,
     18'sd15729
  };
  localparam coef_t C_135 [NTAP] = '{
    -18'sd3277, -18'sd1966, -18'sd328,  18'sd1311, 18'sd3604, -18'sd1311,
     18'sd655,   18'sd4588,  18'sd6226, 18'sd2621, 18'sd2294,  18'sd9830,
     18'sd16384
  };
  localparam coef_t C_180 [NTAP] = '{
     18'sd983,  -18'sd655,  -18'sd2621, -18'sd655,  18'sd983,  18'sd2949,
    -18'sd1638, -18'sd7864, -18'sd1638,  18'sd2949, 18'sd4587, 18'sd9175,
     18'sd14418
  };

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_PREADD,
    ST_MAC,
    ST_READY
  } state_t;

endpackage

// File: rtl/gabor_mac13.sv
// gabor_mac13: combinational 13-tap multiply-accumulate for one orientation.
//   Parameter COEF : 13 signed Q2.15 taps
//   i_sum          : 13 unsigned pair sums
//   o_acc          : signed 34-bit sum of i_sum[j]*COEF[j]
// Build option GABOR_CLAMP_EN: when defined, o_acc is clamped to
// [0, CLAMP_MAX]; otherwise the raw two's-complement sum is passed through.
module gabor_mac13
  import gabor_pkg::*;
#(
  parameter coef_t COEF [NTAP] = '{default: '0}
) (
  input  psum_t                   i_sum [NTAP],
  output logic signed [ACC_W-1:0] o_acc
);

  logic signed [ACC_W-1:0] w_raw;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_raw = '0;
    for (int j = 0; j < NTAP; j++) begin
      // Pair sum is unsigned: prepend a 0 before treating it as signed.
      w_raw = w_raw + ACC_W'($signed({1'b0, i_sum[j]})) * ACC_W'(COEF[j]);
    end
  end

`ifdef GABOR_CLAMP_EN
  always_comb begin
    o_acc = w_raw;
    if (w_raw[ACC_W-1])          o_acc = '0;
    else if (w_raw > CLAMP_MAX)  o_acc = CLAMP_MAX;
  end
`else
  assign o_acc = w_raw;
`endif

endmodule

// File: rtl/gabor_conv5x5.sv
// gabor_conv5x5: streaming 5x5 Gabor convolution over a zero-padded frame.
//   clk, rst               : clock, synchronous active-high reset
//   pixel1..pixel25        : window pixels, row-major, relative to image_addr
//                            (bits [9:8] ignored)
//   image_addr             : window top-left memory index, r*PAD_W+c
//   add_out_45..add_out_180: Q.15 orientation responses, held between MACs
//   data_ready             : one-cycle pulse while results are valid
// Each output takes 4 cycles: FETCH -> PREADD -> MAC -> READY.
// Build option GABOR_CLAMP_EN (see gabor_mac13) clamps each result.
module gabor_conv5x5 #(
  parameter int IMG_W = gabor_pkg::IMG_W,
  parameter int PAD_W = IMG_W + 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [gabor_pkg::PIX_W-1:0]   pixel1,  pixel2,  pixel3,  pixel4,  pixel5,
  input  logic [gabor_pkg::PIX_W-1:0]   pixel6,  pixel7,  pixel8,  pixel9,  pixel10,
  input  logic [gabor_pkg::PIX_W-1:0]   pixel11, pixel12, pixel13, pixel14, pixel15,
  input  logic [gabor_pkg::PIX_W-1:0]   pixel16, pixel17, pixel18, pixel19, pixel20,
  input  logic [gabor_pkg::PIX_W-1:0]   pixel21, pixel22, pixel23, pixel24, pixel25,
  output logic [gabor_pkg::ADDR_W-1:0]  image_addr,
  output logic [gabor_pkg::ACC_W-1:0]   add_out_45,
  output logic [gabor_pkg::ACC_W-1:0]   add_out_90,
  output logic [gabor_pkg::ACC_W-1:0]   add_out_135,
  output logic [gabor_pkg::ACC_W-1:0]   add_out_180,
  output logic                          data_ready
);
  import gabor_pkg::*;

  localparam int                CNT_W    = $clog2(IMG_W);
  localparam logic [CNT_W-1:0]  LAST     = CNT_W'(IMG_W - 1);
  // Jump from the last pixel of a row past the pad columns to the next row.
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(PAD_W - IMG_W + 1);

  state_t                  r_state, w_next;
  logic [CNT_W-1:0]        r_row, r_col;
  logic [ADDR_W-1:0]       r_addr;
  logic [7:0]              w_pix [25];
  psum_t                   w_sum [NTAP];
  psum_t                   r_sum [NTAP];
  logic signed [ACC_W-1:0] w_mac [4];
  logic signed [ACC_W-1:0] r_out [4];
  logic [49:0]             w_unused_hi;

  assign w_pix = '{
    pixel1[7:0],  pixel2[7:0],  pixel3[7:0],  pixel4[7:0],  pixel5[7:0],
    pixel6[7:0],  pixel7[7:0],  pixel8[7:0],  pixel9[7:0],  pixel10[7:0],
    pixel11[7:0], pixel12[7:0], pixel13[7:0], pixel14[7:0], pixel15[7:0],
    pixel16[7:0], pixel17[7:0], pixel18[7:0], pixel19[7:0], pixel20[7:0],
    pixel21[7:0], pixel22[7:0], pixel23[7:0], pixel24[7:0], pixel25[7:0]
  };

  // The two top bits of each pixel carry no image data.
  assign w_unused_hi = {
    pixel1[9:8],  pixel2[9:8],  pixel3[9:8],  pixel4[9:8],  pixel5[9:8],
    pixel6[9:8],  pixel7[9:8],  pixel8[9:8],  pixel9[9:8],  pixel10[9:8],
    pixel11[9:8], pixel12[9:8], pixel13[9:8], pixel14[9:8], pixel15[9:8],
    pixel16[9:8], pixel17[9:8], pixel18[9:8], pixel19[9:8], pixel20[9:8],
    pixel21[9:8], pixel22[9:8], pixel23[9:8], pixel24[9:8], pixel25[9:8]
  };

  // Kernel is centro-symmetric: fold pixel j with its mirror pixel 26-j.
  always_comb begin
    for (int j = 0; j < NTAP - 1; j++) begin
      w_sum[j] = PSUM_W'(w_pix[j]) + PSUM_W'(w_pix[24-j]);
    end
    w_sum[NTAP-1] = PSUM_W'(w_pix[12]);
  end

  gabor_mac13 #(.COEF(C_45))  u_mac_45  (.i_sum(r_sum), .o_acc(w_mac[0]));
  gabor_mac13 #(.COEF(C_90))  u_mac_90  (.i_sum(r_sum), .o_acc(w_mac[1]));
  gabor_mac13 #(.COEF(C_135)) u_mac_135 (.i_sum(r_sum), .o_acc(w_mac[2]));
  gabor_mac13 #(.COEF(C_180)) u_mac_180 (.i_sum(r_sum), .o_acc(w_mac[3]));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = ST_FETCH;
    unique case (r_state)
      ST_FETCH:  w_next = ST_PREADD;
      ST_PREADD: w_next = ST_MAC;
      ST_MAC:    w_next = ST_READY;
      ST_READY:  w_next = ST_FETCH;
      default:   w_next = ST_FETCH;
    endcase
  end

  always_comb begin
    data_ready = 1'b0;
    if (r_state == ST_READY) data_ready = 1'b1;
  end

  // NOTE: the pair-sum array is a pipeline register rather than a RAM, so it
  // is reset with everything else and never shows X after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row  <= '0;
      r_col  <= '0;
      r_addr <= '0;
      for (int j = 0; j < NTAP; j++) r_sum[j] <= '0;
      for (int o = 0; o < 4; o++)    r_out[o] <= '0;
    end else begin
      unique case (r_state)
        ST_PREADD: r_sum <= w_sum;
        ST_MAC:    r_out <= w_mac;
        ST_READY: begin
          if (r_col != LAST) begin
            r_col  <= r_col + 1'b1;
            r_addr <= r_addr + ADDR_W'(1);
          end else if (r_row != LAST) begin
            r_col  <= '0;
            r_row  <= r_row + 1'b1;
            r_addr <= r_addr + ROW_STEP;
          end else begin
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign image_addr  = r_addr;
  assign add_out_45  = r_out[0];
  assign add_out_90  = r_out[1];
  assign add_out_135 = r_out[2];
  assign add_out_180 = r_out[3];

endmodule

// File: tb/tb_gabor_conv5x5.sv
// tb_gabor_conv5x5: directed bench for gabor_conv5x5, built with a 16x16
// frame (stride 20) so full-frame address wrap fits in a short run. A
// behavioural image store answers image_addr combinationally; pixel bits
// [9:8] are driven to 2'b10 throughout to exercise input masking.
module tb_gabor_conv5x5;
  import gabor_pkg::*;

  localparam int TB_W   = 16;
  localparam int TB_PAD = TB_W + 4;
  localparam int TB_MAX = (TB_W - 1) * TB_PAD + (TB_W - 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [PIX_W-1:0]  px [25];
  logic [ADDR_W-1:0] image_addr;
  logic [ACC_W-1:0]  add_out_45, add_out_90, add_out_135, add_out_180;
  logic              data_ready;
  int                mode = 0;
  int                n_checks = 0;
  int                n_err = 0;

  always #5 clk = ~clk;

  gabor_conv5x5 #(.IMG_W(TB_W), .PAD_W(TB_PAD)) dut (
    .clk(clk), .rst(rst),
    .pixel1(px[0]),   .pixel2(px[1]),   .pixel3(px[2]),   .pixel4(px[3]),   .pixel5(px[4]),
    .pixel6(px[5]),   .pixel7(px[6]),   .pixel8(px[7]),   .pixel9(px[8]),   .pixel10(px[9]),
    .pixel11(px[10]), .pixel12(px[11]), .pixel13(px[12]), .pixel14(px[13]), .pixel15(px[14]),
    .pixel16(px[15]), .pixel17(px[16]), .pixel18(px[17]), .pixel19(px[18]), .pixel20(px[19]),
    .pixel21(px[20]), .pixel22(px[21]), .pixel23(px[22]), .pixel24(px[23]), .pixel25(px[24]),
    .image_addr(image_addr),
    .add_out_45(add_out_45), .add_out_90(add_out_90),
    .add_out_135(add_out_135), .add_out_180(add_out_180),
    .data_ready(data_ready)
  );

  // Image contents: 0 = black, 1 = constant 100, 2 = 255 at index 42
  // (row 2, col 2: centre of window 0), 3 = 255 at index 0 (pixel1 of window 0).
  function automatic logic [PIX_W-1:0] pix_at(int idx, int m);
    logic [7:0] b;
    case (m)
      1:       b = 8'd100;
      2:       b = (idx == 2 * TB_PAD + 2) ? 8'd255 : 8'd0;
      3:       b = (idx == 0) ? 8'd255 : 8'd0;
      default: b = 8'd0;
    endcase
    return {2'b10, b};
  endfunction

  always_comb begin
    for (int k = 0; k < 25; k++)
      px[k] = pix_at(int'(image_addr) + (k / 5) * TB_PAD + (k % 5), mode);
  end

  function automatic longint coef(int o, int j);
    case (o)
      0:       return longint'(C_45[j]);
      1:       return longint'(C_90[j]);
      2:       return longint'(C_135[j]);
      default: return longint'(C_180[j]);
    endcase
  endfunction

  function automatic longint clamp_m(longint v);
`ifdef GABOR_CLAMP_EN
    if (v < 0)       return 0;
    if (v > 8388607) return 8388607;
`endif
    return v;
  endfunction

  function automatic longint exp_const(int o);
    longint s = 0;
    for (int j = 0; j < 12; j++) s += coef(o, j);
    return clamp_m(100 * (2 * s + coef(o, 12)));
  endfunction

  function automatic longint out_of(int o);
    case (o)
      0:       return longint'($signed(add_out_45));
      1:       return longint'($signed(add_out_90));
      2:       return longint'($signed(add_out_135));
      default: return longint'($signed(add_out_180));
    endcase
  endfunction

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance negedge by negedge until data_ready, returning cycles waited.
  task automatic wait_ready(output int gap);
    gap = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      gap++;
      if (data_ready) break;
    end
    if (!data_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic check_outs(input string tag, input longint e0, input longint e1,
                            input longint e2, input longint e3);
    check({tag, "_45"},  out_of(0), e0);
    check({tag, "_90"},  out_of(1), e1);
    check({tag, "_135"}, out_of(2), e2);
    check({tag, "_180"}, out_of(3), e3);
  endtask

  // Called at a negedge: hold rst over one rising edge, check the reset
  // state, then release. The first pulse lands in the 4th cycle (FETCH is 1st).
  task automatic pulse_reset(input int next_mode);
    int gap;
    rst = 1'b1;
    @(negedge clk);
    check("rst_addr",  longint'(image_addr), 0);
    check("rst_ready", longint'(data_ready), 0);
    check_outs("rst_out", 0, 0, 0, 0);
    mode = next_mode;
    rst  = 1'b0;
    wait_ready(gap);
    check("rst_first_gap", gap, 3);
  endtask

  initial begin
    int gap;
    int exp_r, exp_c;
    int p;

    // Reset state and full-frame scan of a black image.
    repeat (3) @(negedge clk);
    check("init_addr",  longint'(image_addr), 0);
    check("init_ready", longint'(data_ready), 0);
    check_outs("init_out", 0, 0, 0, 0);
    rst = 1'b0;
    wait_ready(gap);
    check("init_first_gap", gap, 3);

    exp_r = 0;
    exp_c = 0;
    for (p = 0; p <= TB_W * TB_W; p++) begin
      if (p != 0) begin
        wait_ready(gap);
        check("gap", gap, 4);
      end
      check("addr_seq", longint'(image_addr), longint'(exp_r * TB_PAD + exp_c));
      if (p == TB_W)          check("addr_row1", longint'(image_addr), TB_PAD);
      if (p == TB_W * TB_W - 1) check("addr_last", longint'(image_addr), TB_MAX);
      if (p == TB_W * TB_W)   check("addr_wrap", longint'(image_addr), 0);
      check_outs("zero", 0, 0, 0, 0);
      if (exp_c == TB_W - 1) begin
        exp_c = 0;
        exp_r = (exp_r == TB_W - 1) ? 0 : exp_r + 1;
      end else begin
        exp_c++;
      end
    end

    // Constant image, pad included.
    mode = 1;
    for (int i = 0; i < 8; i++) begin
      wait_ready(gap);
      check("const_gap", gap, 4);
      check_outs("const", exp_const(0), exp_const(1), exp_const(2), exp_const(3));
    end

    // Run on to a mid-frame window, then reset there.
    for (int i = 0; i < 300; i++) begin
      if (image_addr == ADDR_W'(72)) break;
      wait_ready(gap);
    end
    check("seek_addr", longint'(image_addr), 72);
    pulse_reset(2);

    // Centre impulse: window 0 sees it at pixel13, window 1 at pixel12.
    check("imp_addr0", longint'(image_addr), 0);
    check_outs("imp_a0", clamp_m(255 * coef(0, 12)), clamp_m(255 * coef(1, 12)),
               clamp_m(255 * coef(2, 12)), clamp_m(255 * coef(3, 12)));
    wait_ready(gap);
    check("imp_addr1", longint'(image_addr), 1);
    check_outs("imp_a1", clamp_m(255 * coef(0, 11)), clamp_m(255 * coef(1, 11)),
               clamp_m(255 * coef(2, 11)), clamp_m(255 * coef(3, 11)));

    // Corner impulse at pixel1: negative 135-degree response.
    pulse_reset(3);
    check_outs("corner", clamp_m(255 * coef(0, 0)), clamp_m(255 * coef(1, 0)),
               clamp_m(255 * coef(2, 0)), clamp_m(255 * coef(3, 0)));
`ifdef GABOR_CLAMP_EN
    check("neg135_clamped", out_of(2), 0);
`else
    check("neg135_raw", out_of(2), -835635);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
